sram1_access_unit: RTL and testbench
====================================

Name: sram1_access_unit

Overview:
Load/store front end that sits directly upstream of SRAM 1 (96 KB at 0x2000_0000–0x2001_7FFF).
- Accepts byte/halfword/word requests from the core using byte addresses.
- Checks range and alignment.
- Converts each request into word-wide SRAM 1 cycles; partial stores use read-modify-write.
- Returns a single response per request.

Parameters:
BASE_ADDR, 32'h2000_0000, first byte address of SRAM 1
SIZE_BYTES, 98304, SRAM 1 capacity in bytes (24576 words)

Ports:
clock  input  1  system clock, posedge
reset_n  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept (high only in IDLE)
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  32  load data, right-aligned, zero-extended
resp_error  output  1  request rejected, no SRAM access made
sram_read_write  output  1  to SRAM 1: 1 = write, 0 = read
sram_address  output  32  to SRAM 1: BASE_ADDR + word index
sram_data_in  output  32  to SRAM 1 write data
sram_data_out  input  32  from SRAM 1; valid only in the high phase after a read edge, Z otherwise

Behaviour:
- Reset:
  - state = IDLE; req_ready = 1.
  - resp_valid = 0, resp_rdata = 0, resp_error = 0.
  - sram_read_write = 0, sram_address = 0, sram_data_in = 0.
  - All SRAM-side outputs are forced asynchronously, so a pending write never commits once reset_n falls.
- SRAM-side outputs are registered:
  - Outside READ and WRITE they hold address 0 (out of SRAM 1 range) with rw = 0, so SRAM 1 is idle.
- Accept on the posedge where req_valid && req_ready. Request fields are latched.
- Word index = (req_addr − BASE_ADDR) >> 2, 15 bits. sram_address = BASE_ADDR | index.
- Byte lane = req_addr[1:0], little-endian.
- Error (checked at accept): any of the following sends the unit straight to RESP with resp_error = 1 and resp_rdata = 0.
  - address outside [BASE_ADDR, BASE_ADDR+SIZE_BYTES−1]
  - req_size = 11
  - halfword with addr[0] = 1
  - word with addr[1:0] ≠ 0
- States and transitions:
  - IDLE → READ: load, or byte/halfword store.
  - IDLE → WRITE: word store.
  - IDLE → RESP: error.
  - READ: drives address with rw = 0. SRAM 1 returns data after the closing posedge. The unit captures sram_data_out on the following negedge into a capture register. → EXTRACT.
  - EXTRACT: a load extracts the lane and registers resp_rdata, then → RESP. A partial store merges req_wdata into the selected lane(s) of the captured word, then → WRITE.
  - WRITE: drives address, rw = 1, merged or full data for one cycle. → RESP.
  - RESP: resp_valid = 1 for exactly one cycle. → IDLE.
- Latency from the accept edge to the resp_valid cycle:
  - error: 1
  - word store: 2
  - load: 3
  - partial store: 4
- req_valid is ignored outside IDLE. Back-to-back requests are accepted on the edge leaving RESP+IDLE (one IDLE cycle minimum).
- Reset mid-operation abandons the request and emits no response.

Optional Feature:
SRAM1_SIGNED_LOAD_EN
- Defined: adds input req_signed (1 bit), latched at accept. Byte and halfword loads with req_signed = 1 are sign-extended. Word loads and stores are unaffected.
- Undefined: the port is absent and all loads are zero-extended.

Decomposition:
- Package sram1_pkg:
  - size encodings (SZ_BYTE/SZ_HALF/SZ_WORD)
  - state enum (IDLE, READ, EXTRACT, WRITE, RESP)
  - SRAM1_BASE and SRAM1_LAST constants
- One combinational sub-module, sram1_lane_merge, handles lane extraction (load) and lane merge (partial store) given size, lane and signedness.

Test Plan:
- Word store to 0x2000_0010 with data 0xDEAD_BEEF → single WRITE cycle at sram_address 0x2000_0004, resp_valid 2 cycles after accept, resp_error = 0. A subsequent word load returns 0xDEAD_BEEF, 3 cycles after its accept.
- Starting from word 0x1122_3344 at 0x2000_0020:
  - byte store 0xAA to 0x2000_0021 → READ, then WRITE of 0x1122_AA44.
  - halfword load at 0x2000_0022 → 0x0000_1122.
- Halfword load at 0x2000_0001, size 11 at 0x2000_0000, and word load at 0x2001_8000 → each gives resp_error = 1, resp_rdata = 0, latency 1, with no READ/WRITE cycle on the SRAM side.
- With SRAM1_SIGNED_LOAD_EN: word 0x0000_0080 stored at 0x2000_0000, then signed byte load at 0x2000_0000 → 0xFFFF_FF80. The unsigned byte load → 0x0000_0080.
- Assert reset_n low during the WRITE cycle of a partial store → the target word is unchanged on readback and no resp_valid is produced.
- req_valid held high with two queued requests → second accepted only after RESP, and req_ready is low throughout READ/EXTRACT/WRITE/RESP.

Source files
------------

// File: rtl/sram1_pkg.sv
// sram1_pkg
//   Shared encodings and constants for the SRAM 1 load/store front end.
//   - size_e      : request size encoding (byte / halfword / word / illegal)
//   - state_e     : access sequencer states
//   - SRAM1_BASE  : first byte address of SRAM 1
//   - SRAM1_SIZE  : SRAM 1 capacity in bytes
//   - SRAM1_LAST  : last byte address of SRAM 1
//   - lane_enables: byte-enable mask for a given size and byte lane
package sram1_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    EXTRACT,
    WRITE,
    RESP
  } state_e;

  localparam logic [31:0] SRAM1_BASE = 32'h2000_0000;
  localparam int unsigned SRAM1_SIZE = 98304;
  localparam logic [31:0] SRAM1_LAST = SRAM1_BASE + 32'(SRAM1_SIZE) - 32'd1;

  // Byte lanes touched by an access of the given size starting at lane.
  // Word accesses are always lane 0, so they simply enable all four lanes.
  function automatic logic [3:0] lane_enables(input size_e size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = 4'b0011 << lane;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/sram1_lane_merge.sv
// sram1_lane_merge
//   Combinational byte-lane handling for SRAM 1 accesses (little-endian).
//   Ports:
//     i_size   : access size (size_e encoding)
//     i_lane   : byte lane of the access (byte address bits [1:0])
//     i_signed : sign-extend byte/halfword load results
//     i_word   : word read from SRAM 1
//     i_wdata  : right-aligned store data
//     o_load   : right-aligned load result (zero- or sign-extended)
//     o_merged : i_word with the store bytes substituted into the selected lanes
module sram1_lane_merge
  import sram1_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  input  logic        i_signed,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  size_e       w_size;
  logic [31:0] w_shifted;
  logic [31:0] w_wdata_shifted;
  logic [3:0]  w_be;

  assign w_size          = size_e'(i_size);
  assign w_shifted       = i_word >> {i_lane, 3'b000};
  assign w_wdata_shifted = i_wdata << {i_lane, 3'b000};
  assign w_be            = lane_enables(w_size, i_lane);

  always_comb begin
    o_load = w_shifted;
    case (w_size)
      SZ_BYTE: o_load = {{24{i_signed & w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: o_load = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
      default: o_load = w_shifted;
    endcase
  end

  always_comb begin
    o_merged = i_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (w_be[i]) begin
        o_merged[8*i +: 8] = w_wdata_shifted[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/sram1_access_unit.sv
// sram1_access_unit
//   Load/store front end sitting directly upstream of SRAM 1. Accepts
//   byte/halfword/word requests by byte address, checks range and alignment,
//   and turns each request into word-wide SRAM 1 cycles. Partial stores use
//   read-modify-write. Exactly one response per accepted request.
//
//   Optional feature macro: SRAM1_SIGNED_LOAD_EN
//     defined   -> extra input req_signed; byte/halfword loads may be sign-extended
//     undefined -> req_signed absent; all loads zero-extended
//
//   Ports:
//     clock, reset_n       : clock (posedge), asynchronous active-low reset
//     req_valid/req_ready  : request handshake (ready only while IDLE)
//     req_write            : 1 = store, 0 = load
//     req_size             : 00 byte, 01 halfword, 10 word, 11 illegal
//     req_addr, req_wdata  : byte address, right-aligned store data
//     req_signed           : (SRAM1_SIGNED_LOAD_EN only) sign-extend load
//     resp_valid           : one-cycle response pulse
//     resp_rdata           : right-aligned load data
//     resp_error           : request rejected, no SRAM access made
//     sram_read_write      : to SRAM 1, 1 = write
//     sram_address         : to SRAM 1, BASE_ADDR | word index
//     sram_data_in         : to SRAM 1 write data
//     sram_data_out        : from SRAM 1, valid in the high phase after a read edge
module sram1_access_unit
  import sram1_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = SRAM1_BASE,
  parameter int unsigned SIZE_BYTES = SRAM1_SIZE
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef SRAM1_SIGNED_LOAD_EN
  input  logic        req_signed,
`endif
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        sram_read_write,
  output logic [31:0] sram_address,
  output logic [31:0] sram_data_in,
  input  logic [31:0] sram_data_out
);

  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(SIZE_BYTES) - 32'd1;

  state_e      r_state;
  state_e      w_next;

  // Latched request
  logic        r_write;
  logic [1:0]  r_size;
  logic [1:0]  r_lane;
  logic [14:0] r_index;
  logic [31:0] r_wdata;
  logic [31:0] r_capture;

  // Request decode (valid while IDLE)
  size_e       w_size;
  logic [31:0] w_offset;
  logic [14:0] w_index;
  logic        w_in_range;
  logic        w_misaligned;
  logic        w_error;
  logic        w_accept;
  logic        w_word_store;

  // SRAM-side next values
  logic [14:0] w_idx_sel;
  logic [31:0] w_wr_data;

  // Lane unit results
  logic        w_signed;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  assign w_size       = size_e'(req_size);
  assign w_offset     = req_addr - BASE_ADDR;
  assign w_index      = 15'(w_offset >> 2);
  assign w_in_range   = (req_addr >= BASE_ADDR) && (req_addr <= LAST_ADDR);
  assign w_misaligned = ((w_size == SZ_HALF) && req_addr[0]) ||
                        ((w_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign w_error      = !w_in_range || (w_size == SZ_BAD) || w_misaligned;
  assign w_accept     = req_valid && (r_state == IDLE);
  assign w_word_store = req_write && (w_size == SZ_WORD);

`ifdef SRAM1_SIGNED_LOAD_EN
  logic r_signed;
  assign w_signed = r_signed;
`else
  assign w_signed = 1'b0;
`endif

  sram1_lane_merge u_lane_merge (
    .i_size   (r_size),
    .i_lane   (r_lane),
    .i_signed (w_signed),
    .i_word   (r_capture),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_error) begin
            w_next = RESP;
          end else if (w_word_store) begin
            w_next = WRITE;
          end else begin
            w_next = READ;
          end
        end
      end
      READ:    w_next = EXTRACT;
      EXTRACT: w_next = r_write ? WRITE : RESP;
      WRITE:   w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    req_ready  = (r_state == IDLE);
    resp_valid = (r_state == RESP);
  end

  // READ/WRITE are entered either straight from IDLE (the request is still on
  // the input bus) or from EXTRACT (use the latched copy and the merged word).
  assign w_idx_sel = (r_state == IDLE) ? w_index : r_index;
  assign w_wr_data = (r_state == IDLE) ? req_wdata : w_merged;

  // Request latch, response registers and SRAM-side registers. The SRAM
  // outputs are loaded from the next state so they are stable for the whole
  // READ/WRITE cycle and return to the idle pattern everywhere else.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_write         <= 1'b0;
      r_size          <= 2'b00;
      r_lane          <= 2'b00;
      r_index         <= '0;
      r_wdata         <= '0;
      resp_rdata      <= '0;
      resp_error      <= 1'b0;
      sram_read_write <= 1'b0;
      sram_address    <= '0;
      sram_data_in    <= '0;
    end else begin
      if (w_accept) begin
        r_write    <= req_write;
        r_size     <= req_size;
        r_lane     <= req_addr[1:0];
        r_index    <= w_index;
        r_wdata    <= req_wdata;
        resp_error <= w_error;
        resp_rdata <= '0;
      end
      if ((r_state == EXTRACT) && !r_write) begin
        resp_rdata <= w_load;
      end
      sram_read_write <= (w_next == WRITE);
      if ((w_next == READ) || (w_next == WRITE)) begin
        sram_address <= BASE_ADDR | {17'd0, w_idx_sel};
      end else begin
        sram_address <= '0;
      end
      sram_data_in <= (w_next == WRITE) ? w_wr_data : '0;
    end
  end

`ifdef SRAM1_SIGNED_LOAD_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_signed <= 1'b0;
    end else if (w_accept) begin
      r_signed <= req_signed;
    end
  end
`endif

  // SRAM 1 read data is only valid in the high phase following the read edge,
  // i.e. the first half of EXTRACT, so it is sampled on that negedge.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_capture <= '0;
    end else if (r_state == EXTRACT) begin
      r_capture <= sram_data_out;
    end
  end

endmodule

// File: tb/tb_sram1_access_unit.sv
// tb_sram1_access_unit
//   Self-checking bench for sram1_access_unit. Contains a simple SRAM 1
//   model, a request-level reference model and a per-cycle compare process.
//   Optional macro SRAM1_SIGNED_LOAD_EN connects and exercises req_signed.
module tb_sram1_access_unit;

  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam logic [31:0] LAST  = 32'h2001_7FFF;
  localparam int          WORDS = 24576;
`ifdef SRAM1_SIGNED_LOAD_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clock     = 1'b0;
  logic        reset_n   = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size  = 2'b00;
  logic [31:0] req_addr  = '0;
  logic [31:0] req_wdata = '0;
`ifdef SRAM1_SIGNED_LOAD_EN
  logic        req_signed = 1'b0;
`endif
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        sram_read_write;
  logic [31:0] sram_address;
  logic [31:0] sram_data_in;
  logic [31:0] sram_data_out;

  sram1_access_unit #(
    .BASE_ADDR  (32'h2000_0000),
    .SIZE_BYTES (98304)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_size        (req_size),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
`ifdef SRAM1_SIGNED_LOAD_EN
    .req_signed      (req_signed),
`endif
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_error      (resp_error),
    .sram_read_write (sram_read_write),
    .sram_address    (sram_address),
    .sram_data_in    (sram_data_in),
    .sram_data_out   (sram_data_out)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic void fail_now(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endfunction

  // SRAM 1 environment model: word-addressed at BASE | index.
  logic [31:0] sram_mem [WORDS];
  logic [31:0] sram_drv = 'z;
  logic [31:0] sram_off;
  assign sram_data_out = sram_drv;

  always @(posedge clock) begin
    sram_off = sram_address - BASE;
    if (sram_off < 32'(WORDS)) begin
      if (sram_read_write) begin
        sram_mem[sram_off[14:0]] = sram_data_in;
      end else begin
        #1 sram_drv = sram_mem[sram_off[14:0]];
        @(negedge clock);
        #1 sram_drv = 'z;
      end
    end
  end

  // Reference model state: memory image plus expectations for the
  // request in flight, expressed as absolute cycle numbers.
  logic [31:0] ref_mem [WORDS];
  logic        rec_valid = 1'b0;
  int          rec_A, rec_L, rec_rd, rec_wr;
  logic        rec_err;
  logic [31:0] rec_rdata, rec_addr, rec_wdata;
  int          undo_idx;
  logic [31:0] undo_val;
  int          pend_cnt;

  // Observations
  int          resp_count = 0;
  int          wr_count   = 0;
  int          rd_count   = 0;
  int          last_resp_cyc;
  logic [31:0] last_rdata, last_wr_addr, last_wr_data;
  logic        last_err;

  function automatic void model_accept(input logic wr, input logic [1:0] sz,
                                       input logic [31:0] addr, input logic [31:0] wd,
                                       input logic sg);
    logic        err;
    logic        sg_eff;
    int          idx, lane, nb;
    logic [31:0] w, val, mask;
    sg_eff   = sg & SIGNED_EN;
    err      = (addr < BASE) || (addr > LAST) || (sz == 2'd3) ||
               (sz == 2'd1 && addr % 2 != 0) || (sz == 2'd2 && addr % 4 != 0);
    pend_cnt  = resp_count;
    rec_A     = cyc + 1;
    rec_err   = err;
    rec_rdata = 32'd0;
    rec_rd    = -1;
    rec_wr    = -1;
    rec_addr  = 32'd0;
    rec_wdata = 32'd0;
    if (err) begin
      rec_L = 1;
    end else begin
      idx      = int'((addr - BASE) / 4);
      lane     = int'(addr % 4);
      nb       = 1 << sz;
      rec_addr = BASE + 32'(idx);
      w        = ref_mem[idx];
      if (!wr) begin
        val = 32'd0;
        for (int b = 0; b < nb; b++) val[8*b +: 8] = w[8*(lane+b) +: 8];
        mask = (nb == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        if (sg_eff && nb < 4 && val[8*nb-1]) val = val | ~mask;
        rec_rdata = val;
        rec_L     = 3;
        rec_rd    = rec_A;
      end else begin
        undo_idx = idx;
        undo_val = w;
        for (int b = 0; b < nb; b++) w[8*(lane+b) +: 8] = wd[8*b +: 8];
        ref_mem[idx] = w;
        rec_wdata    = w;
        if (nb == 4) begin
          rec_L  = 2;
          rec_wr = rec_A;
        end else begin
          rec_L  = 4;
          rec_rd = rec_A;
          rec_wr = rec_A + 2;
        end
      end
    end
    rec_valid = 1'b1;
  endfunction

  // Per-cycle compare process
  logic m_busy, m_resp, m_wr, m_act;
  always @(negedge clock) begin
    if (!reset_n) begin
      chk("rst_req_ready",  32'(req_ready),       32'd1);
      chk("rst_resp_valid", 32'(resp_valid),      32'd0);
      chk("rst_resp_rdata", resp_rdata,           32'd0);
      chk("rst_resp_error", 32'(resp_error),      32'd0);
      chk("rst_sram_rw",    32'(sram_read_write), 32'd0);
      chk("rst_sram_addr",  sram_address,         32'd0);
      chk("rst_sram_din",   sram_data_in,         32'd0);
    end else if (rec_valid) begin
      m_busy = (cyc >= rec_A) && (cyc <= rec_A + rec_L - 1);
      m_resp = (cyc == rec_A + rec_L - 1);
      m_wr   = (cyc == rec_wr);
      m_act  = m_wr || (cyc == rec_rd);
      chk("req_ready",  32'(req_ready),       32'(!m_busy));
      chk("resp_valid", 32'(resp_valid),      32'(m_resp));
      if (m_resp) begin
        chk("resp_error", 32'(resp_error), 32'(rec_err));
        chk("resp_rdata", resp_rdata,      rec_rdata);
      end
      chk("sram_rw",   32'(sram_read_write), 32'(m_wr));
      chk("sram_addr", sram_address,         m_act ? rec_addr : 32'd0);
      if (m_wr) chk("sram_din", sram_data_in, rec_wdata);
    end else begin
      chk("idle_req_ready",  32'(req_ready),       32'd1);
      chk("idle_resp_valid", 32'(resp_valid),      32'd0);
      chk("idle_sram_rw",    32'(sram_read_write), 32'd0);
      chk("idle_sram_addr",  sram_address,         32'd0);
    end
    if (resp_valid) begin
      resp_count++;
      last_rdata    = resp_rdata;
      last_err      = resp_error;
      last_resp_cyc = cyc;
    end
    if (sram_read_write) begin
      wr_count++;
      last_wr_addr = sram_address;
      last_wr_data = sram_data_in;
    end else if (sram_address != 32'd0) begin
      rd_count++;
    end
  end

  task automatic issue(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                       input logic [31:0] wd, input logic sg);
    int n;
    n = 0;
    @(negedge clock); #1;
    req_valid = 1'b1;
    req_write = wr;
    req_size  = sz;
    req_addr  = addr;
    req_wdata = wd;
`ifdef SRAM1_SIGNED_LOAD_EN
    req_signed = sg;
`endif
    while (!req_ready && n < 40) begin
      @(negedge clock); #1;
      n++;
    end
    if (!req_ready) begin
      fail_now("accept_timeout");
      req_valid = 1'b0;
    end else begin
      model_accept(wr, sz, addr, wd, sg);
      @(posedge clock);
    end
  endtask

  task automatic drop_req();
    @(negedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (resp_count == pend_cnt && n < 40) begin
      @(negedge clock); #1;
      n++;
    end
    if (resp_count == pend_cnt) fail_now("resp_timeout");
  endtask

  // Single request, waited to completion, with literal expectations.
  task automatic directed(input string name, input logic wr, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [31:0] wd, input logic sg,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    issue(wr, sz, addr, wd, sg);
    drop_req();
    wait_resp();
    chk({name, "_rdata"}, last_rdata,                         exp_rdata);
    chk({name, "_err"},   32'(last_err),                      32'(exp_err));
    chk({name, "_lat"},   32'(last_resp_cyc - rec_A + 1),     32'(exp_lat));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int a1, rc, wc, rdc, n;
    logic [31:0] v, addr;
    logic [1:0]  sz;

    for (int i = 0; i < WORDS; i++) begin
      v = $urandom;
      sram_mem[i] = v;
      ref_mem[i]  = v;
    end

    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    #1 reset_n = 1'b1;

    // Word store then word load
    directed("wstore", 1'b1, 2'd2, 32'h2000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 2);
    chk("wstore_addr", last_wr_addr, 32'h2000_0004);
    chk("wstore_data", last_wr_data, 32'hDEAD_BEEF);
    directed("wload", 1'b0, 2'd2, 32'h2000_0010, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 3);

    // Partial store via read-modify-write, then halfword load
    directed("wstore2", 1'b1, 2'd2, 32'h2000_0020, 32'h1122_3344, 1'b0, 32'h0, 1'b0, 2);
    directed("bstore", 1'b1, 2'd0, 32'h2000_0021, 32'h0000_00AA, 1'b0, 32'h0, 1'b0, 4);
    chk("bstore_addr", last_wr_addr, 32'h2000_0008);
    chk("bstore_data", last_wr_data, 32'h1122_AA44);
    directed("hload", 1'b0, 2'd1, 32'h2000_0022, 32'h0, 1'b0, 32'h0000_1122, 1'b0, 3);

    // Rejected requests: no SRAM cycles at all
    wc  = wr_count;
    rdc = rd_count;
    directed("err_half", 1'b0, 2'd1, 32'h2000_0001, 32'h0, 1'b0, 32'h0, 1'b1, 1);
    directed("err_size", 1'b0, 2'd3, 32'h2000_0000, 32'h0, 1'b0, 32'h0, 1'b1, 1);
    directed("err_range", 1'b0, 2'd2, 32'h2001_8000, 32'h0, 1'b0, 32'h0, 1'b1, 1);
    chk("err_no_write", 32'(wr_count), 32'(wc));
    chk("err_no_read",  32'(rd_count), 32'(rdc));

    // Sign extension (zero extension when the feature is absent)
    directed("wstore80", 1'b1, 2'd2, 32'h2000_0000, 32'h0000_0080, 1'b0, 32'h0, 1'b0, 2);
    directed("sload", 1'b0, 2'd0, 32'h2000_0000, 32'h0, 1'b1,
             SIGNED_EN ? 32'hFFFF_FF80 : 32'h0000_0080, 1'b0, 3);
    directed("uload", 1'b0, 2'd0, 32'h2000_0000, 32'h0, 1'b0, 32'h0000_0080, 1'b0, 3);

    // Reset during the WRITE cycle of a partial store
    issue(1'b1, 2'd0, 32'h2000_0023, 32'h0000_0077, 1'b0);
    a1 = rec_A;
    drop_req();
    n = 0;
    while (cyc != a1 + 2 && n < 10) begin
      @(negedge clock); #1;
      n++;
    end
    if (cyc != a1 + 2) fail_now("rst_reach_write");
    chk("rst_attempt_data", last_wr_data, 32'h7722_AA44);
    reset_n   = 1'b0;
    rec_valid = 1'b0;
    ref_mem[undo_idx] = undo_val;
    rc = resp_count;
    repeat (2) @(negedge clock);
    #1 reset_n = 1'b1;
    repeat (4) @(negedge clock);
    #1;
    chk("rst_no_resp", 32'(resp_count), 32'(rc));
    directed("rst_readback", 1'b0, 2'd2, 32'h2000_0020, 32'h0, 1'b0, 32'h1122_AA44, 1'b0, 3);

    // Two queued requests with req_valid held high
    issue(1'b1, 2'd2, 32'h2000_0040, 32'hCAFE_F00D, 1'b0);
    a1 = rec_A;
    issue(1'b0, 2'd2, 32'h2000_0040, 32'h0, 1'b0);
    chk("b2b_gap", 32'(rec_A - a1), 32'd3);
    drop_req();
    wait_resp();
    chk("b2b_rdata", last_rdata, 32'hCAFE_F00D);

    // Randomised traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        7:       addr = LAST - 32'($urandom_range(0, 15));
        8:       addr = LAST + 32'd1 + 32'($urandom_range(0, 15));
        9:       addr = BASE - 32'd1 - 32'($urandom_range(0, 15));
        default: addr = BASE + 32'($urandom_range(0, 255));
      endcase
      sz = 2'($urandom_range(0, 3));
      if (sz != 2'd3 && $urandom_range(0, 9) < 7) addr = addr & ~((32'd1 << sz) - 32'd1);
      issue(1'($urandom_range(0, 1)), sz, addr, $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        drop_req();
        repeat ($urandom_range(0, 2)) @(negedge clock);
      end
    end
    drop_req();
    wait_resp();
    repeat (3) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
